csr_unit: RTL and testbench
===========================

// Module: csr_unit
// PURPOSE
//  Parametrised machine-mode CSR/system execution unit; successor to the combinational misc unit for SYSTEM ops.
//  Executes CSRRW/CSRRS/CSRRC(+I), ECALL, EBREAK and MRET. Holds the M-mode CSR file and performs trap entry on commit.
//  Sits beside the other exec units; result goes to writeback/commit. Trap requests arrive from the commit stage.
// PARAMETERS
//  XLEN         32        data width; only 32 supported for *h counter halves
//  HART_ID      0         value returned by mhartid
//  MTVEC_RESET  32'h0     mtvec reset value; bits[1:0] forced 0
// PORTS
//  clk           in   1     clock
//  rst           in   1     asynchronous, active-high reset
//  in_valid      in   1     op presented
//  in_ready      out  1     unit can accept
//  in_op         in   3     csr_op_t: RW,RS,RC,ECALL,EBREAK,MRET,INVAL
//  in_imm_src    in   1     1 = use in_zimm (CSRR*I), 0 = in_rs1_val
//  in_rs1_idx    in   5     rs1 index (zero-write suppression)
//  in_rs1_val    in   XLEN  rs1 operand
//  in_zimm       in   5     zero-extended immediate
//  in_csr_addr   in   12    CSR address
//  in_rd         in   5     destination index
//  out_valid     out  1     result held
//  out_ready     in   1     consumer accepts
//  out_rd_idx    out  5     destination index
//  out_rd_val    out  XLEN  old CSR value
//  out_ex_valid  out  1     exception raised
//  out_ex        out  4     ex_type cause
//  out_ret_valid out  1     MRET; out_br_target = mepc
//  out_br_target out  XLEN  MRET target
//  trap_valid    in   1     commit-stage trap entry (flush)
//  trap_cause    in   XLEN  mcause value
//  trap_pc       in   XLEN  faulting pc -> mepc
//  trap_tval     in   XLEN  -> mtval
//  trap_vector   out  XLEN  mtvec (direct mode)
//  instret_inc   in   1     one instruction retired this cycle
// BEHAVIOUR
//  Reset: in_ready=1, all out_*=0, mstatus.MIE/MPIE=0, MPP=2'b11, mtvec=MTVEC_RESET, others 0.
//  FSM IDLE->HOLD on in_valid&&in_ready; HOLD->IDLE on out_valid&&out_ready. in_ready=(state==IDLE). Latency 1 cycle.
//  Accept cycle: old CSR value sampled into out_rd_val; legality decided; new value computed and held.
//  CSR write commits on output handshake only, and only if !out_ex_valid.
//  RS/RC: no write if rs1_idx==0 (reg) or zimm==0 (imm). RW always writes.
//  Illegal (EX_ILLEGAL_INSTR): unknown address; write attempt to addr[11:10]==2'b11; INVAL op.
//  ECALL -> EX_M_ECALL, EBREAK -> EX_BREAKPOINT; out_rd_val=0.
//  MRET on handshake: MIE<=MPIE, MPIE<=1; out_br_target=mepc.
//  WARL: mtvec[1:0]=0, mepc[1:0]=0, mstatus writable bits 3,7 only; misa/mhartid read-only.
//  trap_valid: highest priority. Same cycle: mepc<=trap_pc&~3, mcause, mtval, MPIE<=MIE, MIE<=0.
//  trap_valid also flushes: state->IDLE, out_valid->0, held write discarded, in_valid that cycle ignored.
//  trap_valid with a handshake in the same cycle: trap wins; held write dropped.
// CONFIGURATION
//  CSR_COUNTERS_EN defined: mcycle/mcycleh/minstret/minstreth (0xB00/B80/B02/B82) are 64-bit and writable.
//    mcycle +1 every cycle; minstret +instret_inc. A CSR write to either half wins over the increment that cycle.
//    Low-half wrap carries into the high half.
//  Undefined: those addresses are unknown -> EX_ILLEGAL_INSTR; no counter flops.
// STRUCTURE
//  csr_pkg: csr_op_t, csr_addr_e constants, mstatus_t struct, MISA value. ex_type comes from types.sv.
//  Sub-module csr_counter64: write-lo/write-hi/increment ports; instantiated twice under CSR_COUNTERS_EN.
// TESTING
//  CSRRW mscratch, rs1=0xDEADBEEF, then CSRRS rs1_idx=0 -> 2nd rd_val=0xDEADBEEF, no write.
//  CSRRW mtvec=0x80000003 -> readback 0x80000000; trap_vector=0x80000000.
//  CSRRS mhartid with rs1_idx=5 -> EX_ILLEGAL_INSTR; mhartid stays HART_ID.
//  out_ready=0 for 3 cycles -> out_* stable, in_ready=0; write commits on handshake cycle only.
//  MIE=1, trap_valid cause=2 pc=0x104 -> MIE=0, MPIE=1, mepc=0x104; MRET -> target 0x104, MIE=1.
//  CSR_COUNTERS_EN: write mcycle=0xFFFFFFFF -> next cycle mcycle=0, mcycleh=1. Undefined: read 0xB00 -> illegal.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types and constants for the machine-mode CSR unit.
//   csr_op_t    : operation presented to the unit
//   ex_type     : exception cause codes reported on out_ex
//   csr_addr_e  : implemented CSR addresses
//   mstatus_t   : machine status register layout
//   state_t     : accept/hold handshake state
package csr_pkg;

    typedef enum logic [2:0] {
        OP_RW     = 3'd0,
        OP_RS     = 3'd1,
        OP_RC     = 3'd2,
        OP_ECALL  = 3'd3,
        OP_EBREAK = 3'd4,
        OP_MRET   = 3'd5,
        OP_INVAL  = 3'd6
    } csr_op_t;

    typedef enum logic [3:0] {
        EX_ILLEGAL_INSTR = 4'd2,
        EX_BREAKPOINT    = 4'd3,
        EX_M_ECALL       = 4'd11
    } ex_type;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MISA      = 12'h301,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MTVAL     = 12'h343,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_MHARTID   = 12'hF14
    } csr_addr_e;

    typedef struct packed {
        logic [18:0] rsv_hi;
        logic [1:0]  mpp;
        logic [2:0]  rsv_mid;
        logic        mpie;
        logic [2:0]  rsv_lo;
        logic        mie;
        logic [2:0]  rsv_base;
    } mstatus_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // RV32I, MXL = 1
    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

endpackage

// File: rtl/csr_counter64.sv
// Two-half free-running counter with independent half writes.
//   clk, rst    : clock, async active-high reset
//   wr_lo_i     : load low half from wdata_i (wins over the increment)
//   wr_hi_i     : load high half from wdata_i
//   wdata_i     : write data
//   inc_i       : add one this cycle
//   value_o     : {high, low}
module csr_counter64 #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_lo_i,
    input  logic           wr_hi_i,
    input  logic [W-1:0]   wdata_i,
    input  logic           inc_i,
    output logic [2*W-1:0] value_o
);

    logic [W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic         carry;

    always_comb begin
        // a written low half never carries out in the same cycle
        carry = inc_i && !wr_lo_i && (lo_q == {W{1'b1}});
        lo_d  = wr_lo_i ? wdata_i : lo_q + {{(W-1){1'b0}}, inc_i};
        hi_d  = wr_hi_i ? wdata_i : hi_q + {{(W-1){1'b0}}, carry};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= '0;
            hi_q <= '0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR / SYSTEM execution unit with commit-stage trap entry.
// Optional feature macro: CSR_COUNTERS_EN (64-bit mcycle/minstret).
//   in_*        : op issue (valid/ready), operands, CSR address, rd
//   out_*       : held result (valid/ready), old CSR value, exception, MRET target
//   trap_*      : trap entry from commit; flushes any held op
//   trap_vector : mtvec, direct mode
//   instret_inc : retire pulse for minstret
//
// state  | meaning
// S_IDLE | ready for a new op
// S_HOLD | result held until out_ready; CSR write pending
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              HART_ID     = 0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_imm_src,
    input  logic [4:0]      in_rs1_idx,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [4:0]      in_zimm,
    input  logic [11:0]     in_csr_addr,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd_idx,
    output logic [XLEN-1:0] out_rd_val,
    output logic            out_ex_valid,
    output logic [3:0]      out_ex,
    output logic            out_ret_valid,
    output logic [XLEN-1:0] out_br_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    output logic [XLEN-1:0] trap_vector,
    input  logic            instret_inc
);

    state_t          state_q, state_d;
    logic            accept, commit;

    logic [4:0]      rd_idx_q;
    logic [XLEN-1:0] rd_val_q, rd_val_d, tgt_q, tgt_d, wdata_q, wdata_d;
    logic            ex_valid_q, ex_valid_d, ret_q, ret_d, wen_q, wen_d;
    logic [3:0]      ex_q, ex_d;
    logic [11:0]     waddr_q;

    logic            mie_q, mpie_q;
    logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

    mstatus_t        mstatus_rd;
    logic [XLEN-1:0] rdata, src;
    logic            known, wr_attempt, csr_wr;

    assign csr_wr = commit && wen_q && !ex_valid_q;

`ifdef CSR_COUNTERS_EN
    logic [2*XLEN-1:0] mcycle, minstret;

    csr_counter64 #(.W(XLEN)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .wr_lo_i (csr_wr && (waddr_q == CSR_MCYCLE)),
        .wr_hi_i (csr_wr && (waddr_q == CSR_MCYCLEH)),
        .wdata_i (wdata_q),
        .inc_i   (1'b1),
        .value_o (mcycle)
    );

    csr_counter64 #(.W(XLEN)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .wr_lo_i (csr_wr && (waddr_q == CSR_MINSTRET)),
        .wr_hi_i (csr_wr && (waddr_q == CSR_MINSTRETH)),
        .wdata_i (wdata_q),
        .inc_i   (instret_inc),
        .value_o (minstret)
    );
`else
    logic unused_instret;
    assign unused_instret = instret_inc;
`endif

    always_comb begin
        mstatus_rd      = '0;
        mstatus_rd.mpp  = 2'b11;
        mstatus_rd.mpie = mpie_q;
        mstatus_rd.mie  = mie_q;
        rdata = '0;
        known = 1'b1;
        case (in_csr_addr)
            CSR_MSTATUS:   rdata = mstatus_rd;
            CSR_MISA:      rdata = XLEN'(MISA_VALUE);
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MHARTID:   rdata = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rdata = mcycle[XLEN-1:0];
            CSR_MCYCLEH:   rdata = mcycle[2*XLEN-1:XLEN];
            CSR_MINSTRET:  rdata = minstret[XLEN-1:0];
            CSR_MINSTRETH: rdata = minstret[2*XLEN-1:XLEN];
`endif
            default:       known = 1'b0;
        endcase
    end

    // result and pending write, captured on accept
    always_comb begin
        src        = in_imm_src ? {{(XLEN-5){1'b0}}, in_zimm} : in_rs1_val;
        // set/clear with a zero source is a pure read
        wr_attempt = (in_op == OP_RW) ||
                     (in_imm_src ? (in_zimm != 5'd0) : (in_rs1_idx != 5'd0));
        rd_val_d   = '0;
        ex_valid_d = 1'b0;
        ex_d       = '0;
        ret_d      = 1'b0;
        tgt_d      = '0;
        wen_d      = 1'b0;
        wdata_d    = '0;
        case (in_op)
            OP_RW, OP_RS, OP_RC: begin
                rd_val_d = rdata;
                if (!known || (wr_attempt && (in_csr_addr[11:10] == 2'b11))) begin
                    ex_valid_d = 1'b1;
                    ex_d       = EX_ILLEGAL_INSTR;
                end else begin
                    wen_d = wr_attempt;
                end
                if (in_op == OP_RW)      wdata_d = src;
                else if (in_op == OP_RS) wdata_d = rdata | src;
                else                     wdata_d = rdata & ~src;
            end
            OP_ECALL: begin
                ex_valid_d = 1'b1;
                ex_d       = EX_M_ECALL;
            end
            OP_EBREAK: begin
                ex_valid_d = 1'b1;
                ex_d       = EX_BREAKPOINT;
            end
            OP_MRET: begin
                ret_d = 1'b1;
                tgt_d = mepc_q;
            end
            default: begin
                ex_valid_d = 1'b1;
                ex_d       = EX_ILLEGAL_INSTR;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: if (in_valid) begin
                state_d = S_HOLD;
                accept  = 1'b1;
            end
            S_HOLD: if (out_ready) begin
                state_d = S_IDLE;
                commit  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // trap flush overrides any handshake in the same cycle
        if (trap_valid) begin
            state_d = S_IDLE;
            accept  = 1'b0;
            commit  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_idx_q   <= '0;
            rd_val_q   <= '0;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            ret_q      <= 1'b0;
            tgt_q      <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            waddr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_idx_q   <= in_rd;
                rd_val_q   <= rd_val_d;
                ex_valid_q <= ex_valid_d;
                ex_q       <= ex_d;
                ret_q      <= ret_d;
                tgt_q      <= tgt_d;
                wen_q      <= wen_d;
                wdata_q    <= wdata_d;
                waddr_q    <= in_csr_addr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
        end else if (trap_valid) begin
            mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (commit) begin
            if (ret_q) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end
            if (csr_wr) begin
                case (waddr_q)
                    CSR_MSTATUS: begin
                        mie_q  <= wdata_q[3];
                        mpie_q <= wdata_q[7];
                    end
                    CSR_MTVEC:    mtvec_q    <= {wdata_q[XLEN-1:2], 2'b00};
                    CSR_MSCRATCH: mscratch_q <= wdata_q;
                    CSR_MEPC:     mepc_q     <= {wdata_q[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= wdata_q;
                    CSR_MTVAL:    mtval_q    <= wdata_q;
                    default: ;
                endcase
            end
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_HOLD);
    assign out_rd_idx    = rd_idx_q;
    assign out_rd_val    = rd_val_q;
    assign out_ex_valid  = ex_valid_q;
    assign out_ex        = ex_q;
    assign out_ret_valid = ret_q;
    assign out_br_target = tgt_q;
    assign trap_vector   = mtvec_q;

endmodule

// File: tb/tb_csr_unit.sv
module tb_csr_unit;
    import csr_pkg::*;

    localparam int          HART     = 3;
    localparam logic [31:0] MTV_RST  = 32'h1000_0001;

    logic        clk, rst;
    logic        in_valid, in_ready, in_imm_src;
    logic [2:0]  in_op;
    logic [4:0]  in_rs1_idx, in_zimm, in_rd, out_rd_idx;
    logic [31:0] in_rs1_val, out_rd_val, out_br_target;
    logic [11:0] in_csr_addr;
    logic        out_valid, out_ready, out_ex_valid, out_ret_valid;
    logic [3:0]  out_ex;
    logic        trap_valid, instret_inc;
    logic [31:0] trap_cause, trap_pc, trap_tval, trap_vector;

    int errors = 0;
    int checks = 0;

    csr_unit #(.XLEN(32), .HART_ID(HART), .MTVEC_RESET(MTV_RST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_imm_src(in_imm_src), .in_rs1_idx(in_rs1_idx), .in_rs1_val(in_rs1_val),
        .in_zimm(in_zimm), .in_csr_addr(in_csr_addr), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd_idx(out_rd_idx),
        .out_rd_val(out_rd_val), .out_ex_valid(out_ex_valid), .out_ex(out_ex),
        .out_ret_valid(out_ret_valid), .out_br_target(out_br_target),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_tval(trap_tval), .trap_vector(trap_vector), .instret_inc(instret_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    // reference model: architectural CSR state
    logic [31:0] m_mscratch, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie;

    // expected / observed result of the last op
    logic        exp_exv, exp_retv, obs_exv, obs_retv;
    logic [3:0]  exp_ex, obs_ex;
    logic [31:0] exp_rv, exp_tgt, obs_rv, obs_tgt;
    logic [4:0]  obs_rd;

    task automatic model_reset();
        m_mscratch = 0; m_mtvec = MTV_RST & ~32'h3; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_mie = 0; m_mpie = 0;
    endtask

    function automatic bit m_known(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h305, 12'h340, 12'h341,
                         12'h342, 12'h343, 12'hF14};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: return 32'h4000_0100;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hF14: return HART;
            default: return 0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h305: m_mtvec = v & ~32'h3;
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & ~32'h3;
            12'h342: m_mcause = v;
            12'h343: m_mtval = v;
            default: ;
        endcase
    endtask

    task automatic model_trap(input logic [31:0] c, input logic [31:0] pc, input logic [31:0] tv);
        m_mepc = pc & ~32'h3; m_mcause = c; m_mtval = tv;
        m_mpie = m_mie; m_mie = 0;
    endtask

    task automatic model_exec(input logic [2:0] op, input logic imm, input logic [4:0] idx,
                              input logic [31:0] val, input logic [4:0] zimm, input logic [11:0] a);
        logic [31:0] s, old;
        bit wr;
        exp_exv = 0; exp_ex = 0; exp_rv = 0; exp_retv = 0; exp_tgt = 0;
        s = imm ? {27'd0, zimm} : val;
        if (op == OP_RW || op == OP_RS || op == OP_RC) begin
            wr = (op == OP_RW) || (imm ? zimm != 0 : idx != 0);
            if (!m_known(a) || (wr && a[11:10] == 2'b11)) begin
                exp_exv = 1; exp_ex = 4'd2;
            end else begin
                old = m_read(a);
                exp_rv = old;
                if (wr) m_write(a, op == OP_RW ? s : (op == OP_RS ? (old | s) : (old & ~s)));
            end
        end else if (op == OP_ECALL) begin
            exp_exv = 1; exp_ex = 4'd11;
        end else if (op == OP_EBREAK) begin
            exp_exv = 1; exp_ex = 4'd3;
        end else if (op == OP_MRET) begin
            exp_retv = 1; exp_tgt = m_mepc;
            m_mie = m_mpie; m_mpie = 1;
        end else begin
            exp_exv = 1; exp_ex = 4'd2;
        end
    endtask

    task automatic drive_in(input logic [2:0] op, input logic imm, input logic [4:0] idx,
                            input logic [31:0] val, input logic [4:0] zimm,
                            input logic [11:0] a, input logic [4:0] rd);
        in_op = op; in_imm_src = imm; in_rs1_idx = idx; in_rs1_val = val;
        in_zimm = zimm; in_csr_addr = a; in_rd = rd;
    endtask

    // issue one op and complete its output handshake; result left in obs_*
    task automatic do_op(input logic [2:0] op, input logic imm, input logic [4:0] idx,
                         input logic [31:0] val, input logic [4:0] zimm,
                         input logic [11:0] a, input logic [4:0] rd);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        drive_in(op, imm, idx, val, zimm, a, rd);
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL op_timeout: out_valid=%0b required 1", out_valid);
        end
        obs_rv = out_rd_val; obs_exv = out_ex_valid; obs_ex = out_ex;
        obs_retv = out_ret_valid; obs_tgt = out_br_target; obs_rd = out_rd_idx;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
    endtask

    task automatic exec(input logic [2:0] op, input logic imm, input logic [4:0] idx,
                        input logic [31:0] val, input logic [4:0] zimm,
                        input logic [11:0] a, input logic [4:0] rd);
        model_exec(op, imm, idx, val, zimm, a);
        do_op(op, imm, idx, val, zimm, a, rd);
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
        checks++; if ({out_valid, out_ex_valid, out_ret_valid} !== 3'b000) begin errors++; $display("FAIL rst_out_flags: got %b want 000", {out_valid, out_ex_valid, out_ret_valid}); end
        checks++; if ({out_rd_val, out_br_target, out_rd_idx, out_ex} !== '0) begin errors++; $display("FAIL rst_out_data: rd_val=%h tgt=%h idx=%0d ex=%0d want 0", out_rd_val, out_br_target, out_rd_idx, out_ex); end
        checks++; if (trap_vector !== 32'h1000_0000) begin errors++; $display("FAIL rst_trap_vector: got %h want 10000000", trap_vector); end
        exec(OP_RS, 0, 0, 32'hFFFF_FFFF, 0, 12'h300, 1);
        checks++; if (obs_rv !== 32'h0000_1800) begin errors++; $display("FAIL rst_mstatus: got %h want 00001800", obs_rv); end
        exec(OP_RS, 0, 0, 0, 0, 12'h301, 2);
        checks++; if (obs_rv !== 32'h4000_0100) begin errors++; $display("FAIL rst_misa: got %h want 40000100", obs_rv); end
        exec(OP_RS, 1, 0, 0, 0, 12'hF14, 3);
        checks++; if (obs_rv !== 32'd3) begin errors++; $display("FAIL rst_mhartid: got %h want 3", obs_rv); end
    endtask

    task automatic test_mscratch();
        exec(OP_RW, 0, 7, 32'hDEAD_BEEF, 0, 12'h340, 4);
        checks++; if (obs_rv !== 0 || obs_rd !== 5'd4) begin errors++; $display("FAIL rw_mscratch: rd_val=%h rd=%0d want 0/4", obs_rv, obs_rd); end
        exec(OP_RS, 0, 0, 32'hFFFF_FFFF, 0, 12'h340, 5);
        checks++; if (obs_rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rs_x0_read: got %h want deadbeef", obs_rv); end
        exec(OP_RC, 1, 0, 0, 0, 12'h340, 5);
        checks++; if (obs_rv !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rs_x0_nowrite: got %h want deadbeef", obs_rv); end
    endtask

    task automatic test_mtvec();
        exec(OP_RW, 0, 3, 32'h8000_0003, 0, 12'h305, 6);
        checks++; if (obs_rv !== 32'h1000_0000) begin errors++; $display("FAIL mtvec_old: got %h want 10000000", obs_rv); end
        exec(OP_RS, 0, 0, 0, 0, 12'h305, 6);
        checks++; if (obs_rv !== 32'h8000_0000) begin errors++; $display("FAIL mtvec_warl: got %h want 80000000", obs_rv); end
        checks++; if (trap_vector !== 32'h8000_0000) begin errors++; $display("FAIL trap_vector: got %h want 80000000", trap_vector); end
    endtask

    task automatic test_mhartid();
        exec(OP_RS, 0, 5, 32'h1, 0, 12'hF14, 7);
        checks++; if (obs_exv !== 1'b1 || obs_ex !== 4'd2) begin errors++; $display("FAIL mhartid_write: ex_valid=%0b ex=%0d want 1/2", obs_exv, obs_ex); end
        exec(OP_RS, 0, 0, 0, 0, 12'hF14, 7);
        checks++; if (obs_exv !== 1'b0 || obs_rv !== 32'd3) begin errors++; $display("FAIL mhartid_keep: ex_valid=%0b rd_val=%h want 0/3", obs_exv, obs_rv); end
        exec(OP_ECALL, 0, 0, 0, 0, 12'h000, 1);
        checks++; if (obs_exv !== 1'b1 || obs_ex !== 4'd11 || obs_rv !== 0) begin errors++; $display("FAIL ecall: ex_valid=%0b ex=%0d rd_val=%h want 1/11/0", obs_exv, obs_ex, obs_rv); end
        exec(OP_EBREAK, 0, 0, 0, 0, 12'h000, 1);
        checks++; if (obs_exv !== 1'b1 || obs_ex !== 4'd3) begin errors++; $display("FAIL ebreak: ex_valid=%0b ex=%0d want 1/3", obs_exv, obs_ex); end
        exec(OP_INVAL, 0, 0, 0, 0, 12'h340, 1);
        checks++; if (obs_exv !== 1'b1 || obs_ex !== 4'd2) begin errors++; $display("FAIL inval: ex_valid=%0b ex=%0d want 1/2", obs_exv, obs_ex); end
    endtask

    task automatic test_back_to_back();
        model_exec(OP_RW, 0, 9, 32'h1111_2222, 0, 12'h340);
        drive_in(OP_RW, 0, 9, 32'h1111_2222, 0, 12'h340, 12);
        in_valid = 1;
        @(posedge clk); #1;
        // a second op offered while holding must not be taken
        drive_in(OP_RW, 0, 9, 32'h0000_0099, 0, 12'h340, 13);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rd_val !== 32'hDEAD_BEEF || out_rd_idx !== 5'd12) begin
                errors++;
                $display("FAIL stall_%0d: valid=%0b in_ready=%0b rd_val=%h rd=%0d want 1/0/deadbeef/12", i, out_valid, in_ready, out_rd_val, out_rd_idx);
            end
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
        exec(OP_RS, 0, 0, 0, 0, 12'h340, 1);
        checks++; if (obs_rv !== 32'h1111_2222) begin errors++; $display("FAIL stall_commit: got %h want 11112222", obs_rv); end
    endtask

    task automatic trap_pulse(input logic [31:0] c, input logic [31:0] pc, input logic [31:0] tv);
        trap_valid = 1; trap_cause = c; trap_pc = pc; trap_tval = tv;
        @(posedge clk); #1;
        trap_valid = 0;
        model_trap(c, pc, tv);
    endtask

    task automatic test_trap_mret();
        exec(OP_RS, 1, 0, 0, 5'd8, 12'h300, 1);
        checks++; if (obs_rv !== 32'h1800) begin errors++; $display("FAIL mie_set_old: got %h want 00001800", obs_rv); end
        trap_pulse(32'd2, 32'h104, 32'hBAD);
        exec(OP_RS, 0, 0, 0, 0, 12'h300, 1);
        checks++; if (obs_rv !== 32'h1880) begin errors++; $display("FAIL trap_mstatus: got %h want 00001880", obs_rv); end
        exec(OP_RS, 0, 0, 0, 0, 12'h341, 1);
        checks++; if (obs_rv !== 32'h104) begin errors++; $display("FAIL trap_mepc: got %h want 00000104", obs_rv); end
        exec(OP_RS, 0, 0, 0, 0, 12'h342, 1);
        checks++; if (obs_rv !== 32'd2) begin errors++; $display("FAIL trap_mcause: got %h want 2", obs_rv); end
        exec(OP_RS, 0, 0, 0, 0, 12'h343, 1);
        checks++; if (obs_rv !== 32'hBAD) begin errors++; $display("FAIL trap_mtval: got %h want bad", obs_rv); end
        exec(OP_MRET, 0, 0, 0, 0, 12'h000, 0);
        checks++; if (obs_retv !== 1'b1 || obs_tgt !== 32'h104 || obs_exv !== 1'b0) begin errors++; $display("FAIL mret: ret=%0b tgt=%h ex=%0b want 1/104/0", obs_retv, obs_tgt, obs_exv); end
        exec(OP_RS, 0, 0, 0, 0, 12'h300, 1);
        checks++; if (obs_rv !== 32'h1888) begin errors++; $display("FAIL mret_mstatus: got %h want 00001888", obs_rv); end
    endtask

    task automatic test_trap_flush();
        drive_in(OP_RW, 0, 1, 32'hCAFE_F00D, 0, 12'h340, 9);
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        out_ready = 1;
        trap_pulse(32'd5, 32'h207, 32'h77);
        out_ready = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_hold: valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
        drive_in(OP_RW, 0, 1, 32'h0000_0055, 0, 12'h340, 9);
        in_valid = 1;
        trap_pulse(32'd7, 32'h300, 32'h0);
        in_valid = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
        exec(OP_RS, 0, 0, 0, 0, 12'h340, 1);
        checks++; if (obs_rv !== 32'h1111_2222) begin errors++; $display("FAIL flush_dropped: got %h want 11112222", obs_rv); end
        exec(OP_RS, 0, 0, 0, 0, 12'h341, 1);
        checks++; if (obs_rv !== 32'h300) begin errors++; $display("FAIL flush_mepc: got %h want 00000300", obs_rv); end
        exec(OP_RS, 0, 0, 0, 0, 12'h300, 1);
        checks++; if (obs_rv !== 32'h1800) begin errors++; $display("FAIL flush_mstatus: got %h want 00001800", obs_rv); end
    endtask

    task automatic test_counters();
`ifdef CSR_COUNTERS_EN
        do_op(OP_RW, 0, 1, 32'hFFFF_FFFF, 0, 12'hB00, 1);
        @(posedge clk); #1;
        do_op(OP_RS, 0, 0, 0, 0, 12'hB80, 2);
        checks++; if (obs_exv !== 1'b0 || obs_rv !== 32'd1) begin errors++; $display("FAIL mcycleh_carry: ex=%0b got %h want 0/1", obs_exv, obs_rv); end
        do_op(OP_RS, 0, 0, 0, 0, 12'hB00, 2);
        checks++; if (obs_rv >= 32'd16) begin errors++; $display("FAIL mcycle_wrap: got %h want below 16", obs_rv); end
        do_op(OP_RW, 0, 1, 32'd5, 0, 12'hB02, 1);
        instret_inc = 1;
        repeat (3) @(posedge clk);
        #1 instret_inc = 0;
        do_op(OP_RS, 0, 0, 0, 0, 12'hB02, 2);
        checks++; if (obs_rv !== 32'd8) begin errors++; $display("FAIL minstret: got %h want 8", obs_rv); end
`else
        do_op(OP_RS, 0, 0, 0, 0, 12'hB00, 2);
        checks++; if (obs_exv !== 1'b1 || obs_ex !== 4'd2) begin errors++; $display("FAIL mcycle_absent: ex_valid=%0b ex=%0d want 1/2", obs_exv, obs_ex); end
`endif
    endtask

    task automatic test_random();
        logic [11:0] addrs [10] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'hF14, 12'h7C0, 12'hC01};
        logic [2:0]  op;
        logic [4:0]  idx, zimm, rd;
        logic [31:0] val;
        logic        imm;
        logic [11:0] a;
        int          r;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2: op = OP_RW;
                3, 4:    op = OP_RS;
                5, 6:    op = OP_RC;
                7:       op = OP_ECALL;
                8:       op = OP_EBREAK;
                9:       op = OP_MRET;
                10:      op = OP_INVAL;
                default: op = 3'd7;
            endcase
            imm  = 1'($urandom_range(0, 1));
            idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            val  = $urandom;
            rd   = 5'($urandom);
            a    = addrs[$urandom_range(0, 9)];
            exec(op, imm, idx, val, zimm, a, rd);
            checks++;
            if (obs_exv !== exp_exv || (exp_exv && obs_ex !== exp_ex)) begin
                errors++;
                $display("FAIL rnd_ex[%0d]: op=%0d addr=%h ex_valid=%0b ex=%0d want %0b/%0d", i, op, a, obs_exv, obs_ex, exp_exv, exp_ex);
            end
            checks++;
            if (!exp_exv && obs_rv !== exp_rv) begin
                errors++;
                $display("FAIL rnd_rdval[%0d]: op=%0d addr=%h got %h want %h", i, op, a, obs_rv, exp_rv);
            end
            checks++;
            if (obs_retv !== exp_retv || (exp_retv && obs_tgt !== exp_tgt) || obs_rd !== rd) begin
                errors++;
                $display("FAIL rnd_ret[%0d]: ret=%0b tgt=%h rd=%0d want %0b/%h/%0d", i, obs_retv, obs_tgt, obs_rd, exp_retv, exp_tgt, rd);
            end
            checks++;
            if (trap_vector !== m_mtvec) begin
                errors++;
                $display("FAIL rnd_tvec[%0d]: got %h want %h", i, trap_vector, m_mtvec);
            end
            if ($urandom_range(0, 15) == 0) trap_pulse($urandom, $urandom, $urandom);
        end
        exec(OP_RS, 0, 0, 0, 0, 12'h300, 1);
        checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL rnd_final_mstatus: got %h want %h", obs_rv, exp_rv); end
    endtask

    initial begin
        rst = 1; in_valid = 0; out_ready = 0; trap_valid = 0; instret_inc = 0;
        drive_in(OP_RW, 0, 0, 0, 0, 0, 0);
        trap_cause = 0; trap_pc = 0; trap_tval = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_mscratch();
        test_mtvec();
        test_mhartid();
        test_back_to_back();
        test_trap_mret();
        test_trap_flush();
        test_counters();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
